// File: rtl/quad_decoder.sv
// Quadrature encoder front-end: two-flop synchroniser, per-channel glitch filter,
// 4x decode into step/dir pulses, wrapping position and saturating error count.
//
// state   | meaning
// ST_INIT | two cycles letting the synchronisers fill
// ST_LOAD | seed filters and prev from synchronised pins, no pulse
// ST_RUN  | normal decode of filtered A/B
module quad_decoder #(
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [CNT_W-1:0] position,
    output logic [7:0]       err_count
);
    typedef enum logic [1:0] {ST_INIT, ST_LOAD, ST_RUN} state_t;

    localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

    state_t           state_q, state_d;
    logic             init_cnt_q, init_cnt_d;
    // two-bit vectors carry channel A in bit 1 and channel B in bit 0
    logic [1:0]       s1_q, s1_d, s2_q, s2_d;
    logic [1:0]       filt_q, filt_d, prev_q, prev_d;
    logic [1:0][7:0]  cnt_q, cnt_d;
    logic             step_q, step_d, dir_q, dir_d, err_q, err_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [1:0]       diff;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        s1_d       = {a_in, b_in};
        s2_d       = s1_q;
        filt_d     = filt_q;
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        err_d      = 1'b0;
        pos_d      = pos_q;
        err_cnt_d  = err_cnt_q;
        diff       = filt_q ^ prev_q;

        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == filt_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = s2_q[i];
                cnt_d[i]  = 8'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end

        unique case (state_q)
            ST_INIT: begin
                init_cnt_d = 1'b1;
                if (init_cnt_q) begin
                    init_cnt_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                filt_d  = s2_q;
                cnt_d   = '0;
                prev_d  = s2_q;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                prev_d = filt_q;
                if (diff == 2'b11) begin
                    err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else if (diff != 2'b00) begin
                    step_d = 1'b1;
                    // the forward successor of {a,b} is {b,~a}
                    dir_d  = (filt_q == {prev_q[0], ~prev_q[1]});
                    pos_d  = dir_d ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (clr) begin
            pos_d     = '0;
            err_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 1'b0;
            s1_q       <= 2'b00;
            s2_q       <= 2'b00;
            filt_q     <= 2'b00;
            cnt_q      <= '0;
            prev_q     <= 2'b00;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            pos_q      <= '0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            pos_q      <= pos_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign step      = step_q;
    assign dir       = dir_q;
    assign err       = err_q;
    assign position  = pos_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: stimulus predicts each decoded event from
// the quadrature rules, a negedge monitor pops and compares on every step/err pulse.
module tb_quad_decoder;
    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_in = 1'b0, b_in = 1'b0, clr = 1'b0;
    logic        step, dir, err;
    logic [15:0] position;
    logic [7:0]  err_count;

    logic        a2 = 1'b0, b2 = 1'b0;
    logic        w_step, w_dir, w_err;
    logic [3:0]  w_pos;
    logic [7:0]  w_ec;

    quad_decoder #(.FILT_LEN(FL), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in), .clr(clr),
        .step(step), .dir(dir), .err(err), .position(position), .err_count(err_count)
    );

    quad_decoder #(.FILT_LEN(1), .CNT_W(4)) u_wrap (
        .clk(clk), .reset_n(reset_n), .a_in(a2), .b_in(b2), .clr(1'b0),
        .step(w_step), .dir(w_dir), .err(w_err), .position(w_pos), .err_count(w_ec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        bit          is_err;
        bit          dir;
        logic [15:0] pos;
        logic [7:0]  ec;
    } exp_t;
    exp_t sb[$];

    logic [1:0] fwd_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] m_filt = 2'b00;
    int         m_pos = 0;
    int         m_ec  = 0;
    int         w_steps = 0, w_errs = 0;

    task automatic chk(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, cyc, actual, actual, expected, expected);
        end
    endtask

    function automatic int seq_idx(input logic [1:0] l);
        for (int i = 0; i < 4; i++) if (fwd_seq[i] == l) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (step || err) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse at cycle %0d: step=%0b err=%0b expected none",
                         cyc, step, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_err", int'(err), int'(e.is_err));
                chk("event_step", int'(step), int'(!e.is_err));
                if (!e.is_err) chk("event_dir", int'(dir), int'(e.dir));
                chk("event_position", int'(position), int'(e.pos));
                chk("event_err_count", int'(err_count), int'(e.ec));
            end
        end
        if (w_step) w_steps++;
        if (w_err)  w_errs++;
    end

    // Drive a level on {A,B} and hold it for 'hold' cycles; predict the decoded event.
    task automatic apply(input logic [1:0] lvl, input int hold, input bit with_clr);
        int   n;
        int   d;
        exp_t e;
        @(posedge clk);
        #1;
        n = cyc;
        {a_in, b_in} = lvl;
        if (hold >= FL && lvl != m_filt) begin
            d = (seq_idx(lvl) - seq_idx(m_filt) + 4) % 4;
            e.is_err = (d == 2);
            e.dir    = (d == 1);
            if (d == 2) m_ec = (m_ec < 255) ? m_ec + 1 : 255;
            else m_pos = (d == 1) ? (m_pos + 1) % 65536 : (m_pos + 65535) % 65536;
            if (with_clr) begin
                m_pos = 0;
                m_ec  = 0;
            end
            e.cyc = n + 3 + FL;
            e.pos = 16'(m_pos);
            e.ec  = 8'(m_ec);
            sb.push_back(e);
            m_filt = lvl;
        end
        if (with_clr) begin
            repeat (2 + FL) @(posedge clk);
            #1 clr = 1'b1;
            @(posedge clk);
            #1 clr = 1'b0;
            repeat (hold - 4 - FL) @(posedge clk);
        end else begin
            repeat (hold - 1) @(posedge clk);
        end
    endtask

    task automatic settle(input string name);
        repeat (FL + 8) @(posedge clk);
        @(negedge clk);
        chk({name, "_pending"}, sb.size(), 0);
        sb.delete();
        chk({name, "_position"}, int'(position), m_pos);
        chk({name, "_err_count"}, int'(err_count), m_ec);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int h;
        logic [1:0] lvl;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_step", int'(step), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_position", int'(position), 0);
        chk("reset_err_count", int'(err_count), 0);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);

        // forward rotation
        for (int i = 1; i <= 4; i++) apply(fwd_seq[i % 4], 10, 1'b0);
        settle("fwd");
        chk("fwd_position_lit", int'(position), 4);

        // reverse rotation, 8 transitions
        for (int i = 1; i <= 8; i++) apply(fwd_seq[(8 - i) % 4], 10, 1'b0);
        settle("rev");
        chk("rev_position_lit", int'(position), 16'hFFFC);

        // glitch rejection, then a pulse exactly FL long
        apply(2'b10, FL - 1, 1'b0);
        apply(2'b00, 10, 1'b0);
        settle("glitch_short");
        apply(2'b10, FL, 1'b0);
        apply(2'b00, 10, 1'b0);
        settle("glitch_exact");
        chk("glitch_position_lit", int'(position), 16'hFFFC);

        // illegal transitions and saturation
        apply(2'b11, FL + 2, 1'b0);
        settle("illegal_one");
        chk("illegal_one_lit", int'(err_count), 1);
        for (int i = 0; i < 299; i++) apply(m_filt ^ 2'b11, FL + 2, 1'b0);
        settle("illegal_sat");
        chk("illegal_sat_lit", int'(err_count), 255);

        // standalone clear
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        m_pos = 0;
        m_ec  = 0;
        settle("clr_idle");

        // randomized walk with legal, illegal and glitch moves
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 3);
            h = $urandom_range(FL + 1, FL + 6);
            lvl = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            case (r)
                0, 1: apply(m_filt ^ lvl, h, 1'b0);
                2:    apply(m_filt ^ 2'b11, h, 1'b0);
                default: begin
                    apply(m_filt ^ lvl, $urandom_range(1, FL - 1), 1'b0);
                    apply(m_filt, h, 1'b0);
                end
            endcase
        end
        settle("random");

        // clear coinciding with a decoded forward step
        apply(fwd_seq[(seq_idx(m_filt) + 1) % 4], 12, 1'b1);
        settle("clr_step");
        chk("clr_step_position_lit", int'(position), 0);

        // rotate forward to level 11, then reset with both pins high
        for (int i = 0; i < 4; i++) apply(fwd_seq[(seq_idx(m_filt) + 1) % 4], 10, 1'b0);
        while (m_filt != 2'b11) apply(fwd_seq[(seq_idx(m_filt) + 1) % 4], 10, 1'b0);
        settle("pre_reset");
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_step", int'(step), 0);
        chk("midreset_err", int'(err), 0);
        chk("midreset_position", int'(position), 0);
        chk("midreset_err_count", int'(err_count), 0);
        reset_n = 1'b1;
        m_pos = 0;
        m_ec  = 0;
        @(posedge clk);
        #1;
        // change lands two edges after release; only seen if LOAD captured 11
        apply(2'b10, 12, 1'b0);
        settle("post_reset");
        chk("post_reset_position_lit", int'(position), 1);

        // wrap on a 4-bit counter with FILT_LEN=1
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1 {a2, b2} = fwd_seq[i % 4];
            repeat (6) @(posedge clk);
            @(negedge clk);
            chk("wrap_position", int'(w_pos), i % 16);
            chk("wrap_dir", int'(w_dir), 1);
        end
        chk("wrap_steps", w_steps, 17);
        chk("wrap_errs", w_errs, 0);
        chk("wrap_err_count", int'(w_ec), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
